// File: rtl/prt_multislot_if.sv
// Byte-stream bundle for the packet reference table: allocation, write beats, read beats, invalidate.
// The master side belongs to the writer, reader and control logic; the slave side belongs to the table.
interface prt_multislot_if #(
  parameter int IDX_W  = 2,
  parameter int DATA_W = 8
);
  logic              slot_free;
  logic              wr_start_req;
  logic              wr_start_ack;
  logic [IDX_W-1:0]  wr_slot;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              err_overflow;
  logic              rd_start;
  logic [IDX_W-1:0]  rd_start_slot;
  logic              rd_busy;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_ready;
  logic              inv_valid;
  logic [IDX_W-1:0]  inv_slot;

  modport master (
    input  slot_free, wr_start_ack, wr_slot, wr_ready, err_overflow,
           rd_busy, rd_valid, rd_data, rd_last,
    output wr_start_req, wr_valid, wr_data, wr_last, rd_start, rd_start_slot,
           rd_ready, inv_valid, inv_slot
  );

  modport slave (
    output slot_free, wr_start_ack, wr_slot, wr_ready, err_overflow,
           rd_busy, rd_valid, rd_data, rd_last,
    input  wr_start_req, wr_valid, wr_data, wr_last, rd_start, rd_start_slot,
           rd_ready, inv_valid, inv_slot
  );
endinterface

// File: rtl/prt_multislot.sv
// Multi-slot frame table with cut-through reads; grant 1 cycle after request, first read beat 2 cycles after rd_start.
// Writer stalls via wr_ready (idle or truncated frame); reader holds rd_data until rd_ready, peak 1 byte per 2 cycles.
module prt_multislot #(
  parameter int NUM_SLOTS  = 4,
  parameter int FRAME_SIZE = 1518,
  parameter int DATA_W     = 8,
  parameter int IDX_W      = $clog2(NUM_SLOTS),
  parameter int LEN_W      = $clog2(FRAME_SIZE + 1)
) (
  input  logic          clk,
  input  logic          reset,
  prt_multislot_if.slave bus
);
  localparam int DEPTH  = NUM_SLOTS * FRAME_SIZE;
  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic       {W_IDLE, W_ACTIVE}       w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_OUT} r_state_t;

  w_state_t             w_state_q, w_state_d;
  r_state_t             r_state_q, r_state_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d, fully_q, fully_d;
  logic [LEN_W-1:0]     bytes_q [NUM_SLOTS];
  logic [LEN_W-1:0]     bytes_d [NUM_SLOTS];
  logic [IDX_W-1:0]     wr_slot_q, wr_slot_d, r_slot_q, r_slot_d;
  logic [LEN_W-1:0]     sent_q, sent_d;
  logic                 ack_q, ack_d, ovf_q, ovf_d, slot_free_q, slot_free_d;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [DATA_W-1:0]    rd_data_q;
  logic                 mem_we, mem_re;
  logic [ADDR_W-1:0]    mem_waddr, mem_raddr;

  logic [IDX_W-1:0]     alloc_idx;
  logic                 inv_wr, inv_rd, wr_fire, rd_fire, rd_last_int, at_limit;

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign inv_wr      = bus.inv_valid && (w_state_q == W_ACTIVE) && (bus.inv_slot == wr_slot_q);
  assign inv_rd      = bus.inv_valid && (r_state_q != R_IDLE) && (bus.inv_slot == r_slot_q);
  assign wr_fire     = bus.wr_valid && (w_state_q == W_ACTIVE) && !inv_wr;
  assign rd_fire     = (r_state_q == R_OUT) && bus.rd_ready;
  assign at_limit    = bytes_q[wr_slot_q] == LEN_W'(FRAME_SIZE - 1);
  assign rd_last_int = (r_state_q == R_OUT) && fully_q[r_slot_q] &&
                       ((sent_q + LEN_W'(1)) == bytes_q[r_slot_q]);
  assign mem_waddr   = ADDR_W'(wr_slot_q) * ADDR_W'(FRAME_SIZE) + ADDR_W'(bytes_q[wr_slot_q]);
  assign mem_raddr   = ADDR_W'(r_slot_q) * ADDR_W'(FRAME_SIZE) + ADDR_W'(sent_q);

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    valid_d   = valid_q;
    fully_d   = fully_q;
    bytes_d   = bytes_q;
    wr_slot_d = wr_slot_q;
    r_slot_d  = r_slot_q;
    sent_d    = sent_q;
    ack_d     = 1'b0;
    ovf_d     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (w_state_q)
      W_IDLE: begin
        if (bus.wr_start_req && slot_free_q) begin
          valid_d[alloc_idx] = 1'b1;
          fully_d[alloc_idx] = 1'b0;
          bytes_d[alloc_idx] = '0;
          wr_slot_d          = alloc_idx;
          ack_d              = 1'b1;
          w_state_d          = W_ACTIVE;
        end
      end
      default: begin
        if (inv_wr) begin
          w_state_d = W_IDLE;
        end else if (wr_fire) begin
          mem_we             = 1'b1;
          bytes_d[wr_slot_q] = bytes_q[wr_slot_q] + LEN_W'(1);
          // A full slot closes the frame even without wr_last; the tail is dropped.
          if (bus.wr_last || at_limit) begin
            fully_d[wr_slot_q] = 1'b1;
            ovf_d              = !bus.wr_last;
            w_state_d          = W_IDLE;
          end
        end
      end
    endcase

    case (r_state_q)
      R_IDLE: begin
        if (bus.rd_start && valid_q[bus.rd_start_slot]) begin
          r_slot_d  = bus.rd_start_slot;
          sent_d    = '0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        // Cut-through stall: wait here until the writer has stored the next byte.
        if (inv_rd) begin
          r_state_d = R_IDLE;
        end else if (sent_q < bytes_q[r_slot_q]) begin
          mem_re    = 1'b1;
          r_state_d = R_OUT;
        end
      end
      R_OUT: begin
        if (rd_fire) begin
          sent_d = sent_q + LEN_W'(1);
          if (rd_last_int) begin
            valid_d[r_slot_q] = 1'b0;
            r_state_d         = R_IDLE;
          end else begin
            r_state_d = R_FETCH;
          end
        end
        if (inv_rd) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase

    // Guarded so that invalidating a free slot cannot cancel a same-cycle allocation of it.
    if (bus.inv_valid && valid_q[bus.inv_slot]) valid_d[bus.inv_slot] = 1'b0;

    slot_free_d = (w_state_d == W_IDLE) && !(&valid_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      r_state_q   <= R_IDLE;
      valid_q     <= '0;
      fully_q     <= '0;
      bytes_q     <= '{default: '0};
      wr_slot_q   <= '0;
      r_slot_q    <= '0;
      sent_q      <= '0;
      ack_q       <= 1'b0;
      ovf_q       <= 1'b0;
      slot_free_q <= 1'b1;
    end else begin
      w_state_q   <= w_state_d;
      r_state_q   <= r_state_d;
      valid_q     <= valid_d;
      fully_q     <= fully_d;
      bytes_q     <= bytes_d;
      wr_slot_q   <= wr_slot_d;
      r_slot_q    <= r_slot_d;
      sent_q      <= sent_d;
      ack_q       <= ack_d;
      ovf_q       <= ovf_d;
      slot_free_q <= slot_free_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.wr_data;
    if (mem_re) rd_data_q <= mem[mem_raddr];
  end

  assign bus.slot_free    = !reset && slot_free_q;
  assign bus.wr_start_ack = !reset && ack_q;
  assign bus.wr_slot      = reset ? '0 : wr_slot_q;
  assign bus.wr_ready     = !reset && (w_state_q == W_ACTIVE);
  assign bus.err_overflow = !reset && ovf_q;
  assign bus.rd_busy      = !reset && (r_state_q != R_IDLE);
  assign bus.rd_valid     = !reset && (r_state_q == R_OUT);
  assign bus.rd_data      = reset ? '0 : rd_data_q;
  assign bus.rd_last      = !reset && rd_last_int;
endmodule
